// File: rtl/song_recorder.sv
// song_recorder: records player key presses as {note, duration} entries into a small
// song RAM using the song ROM encoding, with a registered read port for playback.
module song_recorder #(
    parameter int unsigned TICK_DIV = 20,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned DUR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       key_in,
    input  logic             rec_start,
    input  logic             rec_stop,
    input  logic [4:0]       rd_addr,
    output logic [3:0]       rd_note,
    output logic [DUR_W-1:0] rd_duration,
    output logic [5:0]       rec_len,
    output logic             recording,
    output logic             full,
    output logic             wr_pulse
);

    localparam int unsigned      PrescW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned      EntryW    = 4 + DUR_W;
    localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);
    localparam logic [5:0]       LastLen   = 6'(DEPTH - 1);
    localparam logic [DUR_W-1:0] DurMax    = {DUR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StArm, StRec, StDone} state_e;

    state_e              state_q, state_d;
    logic [6:0]          key_meta_q, key_sync_q;
    logic [3:0]          code;
    logic [3:0]          cur_note_q, cur_note_d;
    logic [DUR_W-1:0]    dur_q, dur_d, dur_eff;
    logic [PrescW-1:0]   presc_q, presc_d;
    logic [4:0]          wr_ptr_q, wr_ptr_d;
    logic [5:0]          rec_len_q, rec_len_d;
    logic                full_q, full_d;
    logic                wr_pulse_q, wr_pulse_d;
    logic                tick_wrap, note_change, wr_en, last_write;
    logic [EntryW-1:0]   mem [DEPTH];
    logic [EntryW-1:0]   rd_data_q;

    // Two-flop synchronizer for the asynchronous key inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta_q <= '0;
            key_sync_q <= '0;
        end else begin
            key_meta_q <= key_in;
            key_sync_q <= key_meta_q;
        end
    end

    // Priority encode: lowest pressed key wins, no key is a rest (0)
    always_comb begin
        code = 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (key_sync_q[i]) code = 4'(i + 1);
        end
    end

    // Commit decision; dur_eff folds in the tick that completes on this very edge
    always_comb begin
        tick_wrap   = (presc_q == PrescLast);
        dur_eff     = (tick_wrap && (dur_q != DurMax)) ? dur_q + DUR_W'(1) : dur_q;
        note_change = (code != cur_note_q);
        wr_en       = 1'b0;
        if ((state_q == StRec) && !rec_start) begin
            if (rec_stop) begin
                // A trailing rest is never stored
                wr_en = (dur_eff != '0) && (cur_note_q != 4'd0);
            end else if (note_change) begin
                // Changes shorter than one tick are glitches and are dropped
                wr_en = (dur_eff != '0);
            end
        end
        last_write = wr_en && (rec_len_q == LastLen);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cur_note_q <= '0;
            dur_q      <= '0;
            presc_q    <= '0;
            wr_ptr_q   <= '0;
            rec_len_q  <= '0;
            full_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_note_q <= cur_note_d;
            dur_q      <= dur_d;
            presc_q    <= presc_d;
            wr_ptr_q   <= wr_ptr_d;
            rec_len_q  <= rec_len_d;
            full_q     <= full_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Next-state logic; rec_start beats everything, a filling write forces DONE
    always_comb begin
        state_d = state_q;
        if (rec_start) begin
            state_d = StArm;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StArm: begin
                    if (rec_stop) begin
                        state_d = StIdle;
                    end else if (code != 4'd0) begin
                        state_d = StRec;
                    end
                end
                StRec: begin
                    if (rec_stop || last_write) state_d = StDone;
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next values: note tracking, tick prescaler, write pointer and length
    always_comb begin
        cur_note_d = cur_note_q;
        dur_d      = dur_q;
        presc_d    = presc_q;
        wr_ptr_d   = wr_ptr_q;
        rec_len_d  = rec_len_q;
        full_d     = full_q;
        wr_pulse_d = wr_en;
        if (rec_start) begin
            wr_ptr_d  = '0;
            rec_len_d = '0;
            full_d    = 1'b0;
            dur_d     = '0;
            presc_d   = '0;
        end else begin
            unique case (state_q)
                StArm: begin
                    if (!rec_stop && (code != 4'd0)) begin
                        cur_note_d = code;
                        dur_d      = '0;
                        presc_d    = '0;
                    end
                end
                StRec: begin
                    if (!rec_stop) begin
                        if (note_change) begin
                            cur_note_d = code;
                            dur_d      = '0;
                            presc_d    = '0;
                        end else begin
                            presc_d = tick_wrap ? '0 : presc_q + PrescW'(1);
                            dur_d   = dur_eff;
                        end
                    end
                end
                default: ;
            endcase
            if (wr_en) begin
                wr_ptr_d  = wr_ptr_q + 5'd1;
                rec_len_d = rec_len_q + 6'd1;
                full_d    = last_write;
            end
        end
    end

    // Song RAM write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {cur_note_q, dur_eff};
    end

    // Registered read port; a same-cycle write to rd_addr returns the old entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_note     = rd_data_q[EntryW-1 -: 4];
    assign rd_duration = rd_data_q[DUR_W-1:0];
    assign rec_len     = rec_len_q;
    assign full        = full_q;
    assign wr_pulse    = wr_pulse_q;
    assign recording   = (state_q == StArm) || (state_q == StRec);

endmodule

// File: tb/tb_song_recorder.sv
// Bench for song_recorder: directed scenarios plus random key sessions checked against a
// run-length reference model of the recorded melody.
module tb_song_recorder;

    localparam int TICK  = 4;
    localparam int DEP   = 32;
    localparam int DW    = 8;
    localparam int DMAX  = (1 << DW) - 1;
    localparam int HIST  = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    key_in = '0;
    logic          rec_start = 1'b0;
    logic          rec_stop = 1'b0;
    logic [4:0]    rd_addr = '0;
    logic [3:0]    rd_note;
    logic [DW-1:0] rd_duration;
    logic [5:0]    rec_len;
    logic          recording;
    logic          full;
    logic          wr_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_count = 0;
    int s_edge = 0;
    int p_edge = 0;
    int wr0 = 0;
    int exp_len = 0;
    logic exp_full = 1'b0;
    logic [3:0] exp_note [DEP];
    int exp_dur [DEP];
    logic [6:0] key_hist [HIST];

    song_recorder #(
        .TICK_DIV(TICK),
        .DEPTH(DEP),
        .DUR_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_in(key_in),
        .rec_start(rec_start),
        .rec_stop(rec_stop),
        .rd_addr(rd_addr),
        .rd_note(rd_note),
        .rd_duration(rd_duration),
        .rec_len(rec_len),
        .recording(recording),
        .full(full),
        .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter, key history as sampled at each edge, and write-pulse counter
    always @(posedge clk) begin
        if (cyc < HIST) key_hist[cyc] <= key_in;
        cyc <= cyc + 1;
        if (wr_pulse === 1'b1) wr_count <= wr_count + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] k, input int n);
        key_in = k;
        tick(n);
    endtask

    // Note value the recorder sees at edge e: the key two sampling edges earlier
    function automatic logic [3:0] code_at(input int e);
        logic [6:0] k;
        if (e < 2) return 4'd0;
        k = key_hist[e-2];
        for (int i = 0; i < 7; i++) begin
            if (k[i]) return 4'(i + 1);
        end
        return 4'd0;
    endfunction

    task automatic push(input logic [3:0] note, input int d);
        exp_note[exp_len] = note;
        exp_dur[exp_len] = d;
        exp_len++;
        if (exp_len == DEP) exp_full = 1'b1;
    endtask

    // Reference: split the note stream between arming (edge s) and stop (edge p) into
    // runs; each run lasting K edges is worth min(K/TICK, DMAX) ticks.
    task automatic model_session(input int s, input int p);
        int first, start, d;
        logic [3:0] note;
        exp_len = 0;
        exp_full = 1'b0;
        first = -1;
        for (int e = s + 1; e < p; e++) begin
            if (code_at(e) != 4'd0) begin
                first = e;
                break;
            end
        end
        if (first < 0) return;
        note = code_at(first);
        start = first;
        for (int e = first + 1; e <= p; e++) begin
            d = (e - start) / TICK;
            if (d > DMAX) d = DMAX;
            if (e == p) begin
                if (d > 0 && note != 4'd0) push(note, d);
                break;
            end
            if (code_at(e) != note) begin
                if (d > 0) push(note, d);
                if (exp_len == DEP) break;
                note = code_at(e);
                start = e;
            end
        end
    endtask

    task automatic read_entry(input int a, output logic [3:0] n, output int d);
        rd_addr = 5'(a);
        tick(1);
        n = rd_note;
        d = int'(rd_duration);
    endtask

    task automatic begin_session();
        s_edge = cyc;
        wr0 = wr_count;
        rec_start = 1'b1;
        tick(1);
        rec_start = 1'b0;
    endtask

    task automatic end_session();
        logic [3:0] n;
        int d;
        p_edge = cyc;
        rec_stop = 1'b1;
        tick(1);
        rec_stop = 1'b0;
        tick(4);
        model_session(s_edge, p_edge);
        chk("rec_len", 32'(rec_len), 32'(exp_len));
        chk("full", 32'(full), 32'(exp_full));
        chk("recording", 32'(recording), 32'd0);
        chk("wr_pulses", 32'(wr_count - wr0), 32'(exp_len));
        for (int i = 0; i < exp_len; i++) begin
            read_entry(i, n, d);
            chk($sformatf("note[%0d]", i), 32'(n), 32'(exp_note[i]));
            chk($sformatf("dur[%0d]", i), 32'(d), 32'(exp_dur[i]));
        end
    endtask

    initial begin
        logic [3:0] n;
        int d;

        // Reset values
        tick(3);
        chk("rst_rd_note", 32'(rd_note), 32'd0);
        chk("rst_rd_duration", 32'(rd_duration), 32'd0);
        chk("rst_rec_len", 32'(rec_len), 32'd0);
        chk("rst_recording", 32'(recording), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        reset = 1'b1;
        tick(2);
        rec_stop = 1'b1;
        tick(1);
        rec_stop = 1'b0;
        tick(2);
        chk("idle_stop_recording", 32'(recording), 32'd0);
        chk("idle_stop_rec_len", 32'(rec_len), 32'd0);
        chk("idle_stop_wr_pulses", 32'(wr_count), 32'd0);

        // Basic capture: note 1 for 40 clocks, note 3 for 20 clocks
        begin_session();
        chk("arm_recording", 32'(recording), 32'd1);
        hold(7'b0000001, 40);
        hold(7'b0000100, 22);
        end_session();
        chk("basic_len", 32'(rec_len), 32'd2);
        read_entry(0, n, d);
        chk("basic_note0", 32'(n), 32'd1);
        chk("basic_dur0", 32'(d), 32'd10);
        read_entry(1, n, d);
        chk("basic_note1", 32'(n), 32'd3);
        chk("basic_dur1", 32'(d), 32'd5);

        // Encoding, leading rest, inner rest, trailing rest
        hold(7'b0, 4);
        begin_session();
        hold(7'b0, 10);
        hold(7'b0000110, 16);
        hold(7'b0, 12);
        hold(7'b0000001, 16);
        hold(7'b0, 10);
        end_session();
        chk("enc_len", 32'(rec_len), 32'd3);
        read_entry(0, n, d);
        chk("enc_note0", 32'(n), 32'd2);
        read_entry(1, n, d);
        chk("rest_note", 32'(n), 32'd0);
        chk("rest_dur", 32'(d), 32'd3);

        // Glitch filter: 2-clock blip of note 7 between notes 1 and 2
        hold(7'b0, 4);
        begin_session();
        hold(7'b0000001, 16);
        hold(7'b1000000, 2);
        hold(7'b0000010, 16);
        end_session();
        chk("glitch_len", 32'(rec_len), 32'd2);
        read_entry(1, n, d);
        chk("glitch_note1", 32'(n), 32'd2);
        chk("glitch_dur1", 32'(d), 32'd3);

        // Stop on the same edge as a note change: only the old note is written
        hold(7'b0, 4);
        begin_session();
        hold(7'b0000001, 16);
        hold(7'b0000010, 2);
        end_session();
        chk("simul_len", 32'(rec_len), 32'd1);

        // rec_start together with rec_stop arms
        hold(7'b0, 4);
        s_edge = cyc;
        wr0 = wr_count;
        rec_start = 1'b1;
        rec_stop = 1'b1;
        tick(1);
        rec_start = 1'b0;
        rec_stop = 1'b0;
        chk("start_stop_recording", 32'(recording), 32'd1);
        hold(7'b0010000, 12);
        end_session();

        // Fill the RAM: 34 alternating 8-clock notes
        hold(7'b0, 4);
        begin_session();
        for (int i = 0; i < 34; i++) hold((i % 2 == 0) ? 7'b0000001 : 7'b0000010, 8);
        end_session();
        chk("full_len", 32'(rec_len), 32'd32);
        chk("full_flag", 32'(full), 32'd1);
        hold(7'b0, 4);
        begin_session();
        chk("restart_len", 32'(rec_len), 32'd0);
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_recording", 32'(recording), 32'd1);
        hold(7'b0, 4);
        end_session();

        // Duration saturation
        hold(7'b0, 4);
        begin_session();
        hold(7'b0001000, TICK * (DMAX + 1) + 8);
        end_session();
        read_entry(0, n, d);
        chk("sat_note", 32'(n), 32'd4);
        chk("sat_dur", 32'(d), 32'(DMAX));

        // Random sessions
        for (int s = 0; s < 12; s++) begin
            begin_session();
            for (int g = 0; g < int'($urandom_range(3, 12)); g++) begin
                if ($urandom_range(0, 2) == 0) hold(7'b0, int'($urandom_range(1, 16)));
                else hold(7'($urandom_range(1, 127)), int'($urandom_range(1, 16)));
            end
            end_session();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
